// File: rtl/bf_pkg.sv
// Shared constants for the multilane butterfly: default coefficient width and
// modulus, the modular half constant, and the NTT/INTT mode encoding.
package bf_pkg;

  localparam int   DEF_DW    = 12;
  localparam int   DEF_Q     = 3329;
  localparam int   QHALF     = (DEF_Q + 1) / 2;
  localparam logic MODE_NTT  = 1'b0;
  localparam logic MODE_INTT = 1'b1;

endpackage

// File: rtl/bf_lane.sv
// One 4-point butterfly lane: two stages of (multiply | reduce + add/sub), four
// register stages in total. MULTILANE_BF_INTT_HALF_EN halves every INTT stage output.
module bf_lane
  import bf_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int Q  = DEF_Q
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            adv,
  input  logic [3:0]      mode_s,
  input  logic [4*DW-1:0] x,
  input  logic [3*DW-1:0] w,
  output logic [4*DW-1:0] y
);

  typedef logic [DW-1:0]   coef_t;
  typedef logic [2*DW-1:0] prod_t;

  localparam logic [DW:0] QE = (DW + 1)'(Q);
  localparam prod_t       QP = (2 * DW)'(Q);

  function automatic coef_t add_q(input coef_t a, input coef_t b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= QE) ? coef_t'(s - QE) : coef_t'(s);
  endfunction

  function automatic coef_t sub_q(input coef_t a, input coef_t b);
    logic [DW:0] s;
    s = {1'b0, a} + QE - {1'b0, b};
    return (a >= b) ? coef_t'(a - b) : coef_t'(s);
  endfunction

  function automatic coef_t red_q(input prod_t p);
    return coef_t'(p % QP);
  endfunction

`ifdef MULTILANE_BF_INTT_HALF_EN
  function automatic coef_t half_q(input coef_t v);
    logic [DW:0] s;
    s = {1'b0, v} + QE;
    return v[0] ? coef_t'(s >> 1) : coef_t'(v >> 1);
  endfunction
`else
  function automatic coef_t half_q(input coef_t v);
    return v;
  endfunction
`endif

  // CT keeps a and forms w*b; GS forms a+b and (a-b)*w
  function automatic coef_t mul_u(input logic gs, input coef_t a, input coef_t b);
    return gs ? add_q(a, b) : a;
  endfunction

  function automatic prod_t mul_p(input logic gs, input coef_t a, input coef_t b, input coef_t c);
    coef_t m;
    m = gs ? sub_q(a, b) : b;
    return prod_t'(m) * prod_t'(c);
  endfunction

  logic  g0, g1, g2, g3;
  coef_t xs [4];
  coef_t ws [3];
  coef_t a1 [2], b1 [2], c1 [2];
  coef_t a2 [2], b2 [2], c2 [2];
  coef_t r1 [2], r3 [2];
  coef_t o1a [2], o1b [2], o2a [2], o2b [2];
  coef_t t_d [4], y_d [4];

  coef_t s1_u [2];
  prod_t s1_p [2];
  coef_t s1_w [3];
  coef_t s2_t [4];
  coef_t s2_w [3];
  coef_t s3_u [2];
  prod_t s3_p [2];
  coef_t s4_y [4];

  assign g0 = (mode_s[0] == MODE_INTT);
  assign g1 = (mode_s[1] == MODE_INTT);
  assign g2 = (mode_s[2] == MODE_INTT);
  assign g3 = (mode_s[3] == MODE_INTT);

  always_comb begin
    for (int i = 0; i < 4; i++) xs[i] = x[i*DW +: DW];
    for (int i = 0; i < 3; i++) ws[i] = w[i*DW +: DW];
    if (g0) begin
      a1[0] = xs[0]; b1[0] = xs[1]; c1[0] = ws[1];
      a1[1] = xs[2]; b1[1] = xs[3]; c1[1] = ws[2];
    end else begin
      a1[0] = xs[0]; b1[0] = xs[2]; c1[0] = ws[0];
      a1[1] = xs[1]; b1[1] = xs[3]; c1[1] = ws[0];
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      r1[k]  = red_q(s1_p[k]);
      o1a[k] = g1 ? half_q(s1_u[k]) : add_q(s1_u[k], r1[k]);
      o1b[k] = g1 ? half_q(r1[k])   : sub_q(s1_u[k], r1[k]);
    end
    if (g1) begin
      t_d[0] = o1a[0]; t_d[1] = o1b[0]; t_d[2] = o1a[1]; t_d[3] = o1b[1];
    end else begin
      t_d[0] = o1a[0]; t_d[1] = o1a[1]; t_d[2] = o1b[0]; t_d[3] = o1b[1];
    end
  end

  always_comb begin
    if (g2) begin
      a2[0] = s2_t[0]; b2[0] = s2_t[2]; c2[0] = s2_w[0];
      a2[1] = s2_t[1]; b2[1] = s2_t[3]; c2[1] = s2_w[0];
    end else begin
      a2[0] = s2_t[0]; b2[0] = s2_t[1]; c2[0] = s2_w[1];
      a2[1] = s2_t[2]; b2[1] = s2_t[3]; c2[1] = s2_w[2];
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      r3[k]  = red_q(s3_p[k]);
      o2a[k] = g3 ? half_q(s3_u[k]) : add_q(s3_u[k], r3[k]);
      o2b[k] = g3 ? half_q(r3[k])   : sub_q(s3_u[k], r3[k]);
    end
    if (g3) begin
      y_d[0] = o2a[0]; y_d[1] = o2a[1]; y_d[2] = o2b[0]; y_d[3] = o2b[1];
    end else begin
      y_d[0] = o2a[0]; y_d[1] = o2b[0]; y_d[2] = o2a[1]; y_d[3] = o2b[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        s1_u[i] <= '0;
        s1_p[i] <= '0;
        s3_u[i] <= '0;
        s3_p[i] <= '0;
      end
      for (int i = 0; i < 3; i++) begin
        s1_w[i] <= '0;
        s2_w[i] <= '0;
      end
      for (int i = 0; i < 4; i++) begin
        s2_t[i] <= '0;
        s4_y[i] <= '0;
      end
    end else if (adv) begin
      for (int i = 0; i < 2; i++) begin
        s1_u[i] <= mul_u(g0, a1[i], b1[i]);
        s1_p[i] <= mul_p(g0, a1[i], b1[i], c1[i]);
        s3_u[i] <= mul_u(g2, a2[i], b2[i]);
        s3_p[i] <= mul_p(g2, a2[i], b2[i], c2[i]);
      end
      for (int i = 0; i < 3; i++) begin
        s1_w[i] <= ws[i];
        s2_w[i] <= s1_w[i];
      end
      for (int i = 0; i < 4; i++) begin
        s2_t[i] <= t_d[i];
        s4_y[i] <= y_d[i];
      end
    end
  end

  assign y = {s4_y[3], s4_y[2], s4_y[1], s4_y[0]};

endmodule

// File: rtl/multilane_bf.sv
// Multilane 4-point NTT/INTT butterfly with valid/ready handshake and a 4-cycle
// stall-able pipeline. Define MULTILANE_BF_INTT_HALF_EN to halve INTT stage outputs.
module multilane_bf
  import bf_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int Q     = DEF_Q,
  parameter int LANES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mode,
  input  logic [LANES*4*DW-1:0] x,
  input  logic [LANES*3*DW-1:0] w,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*4*DW-1:0] y,
  output logic                  out_mode
);

  logic [3:0] vld;
  logic [3:0] mds;
  logic       adv;

  assign out_valid = vld[3];
  assign out_mode  = mds[3];
  // Forced high while rst is low so upstream never sees backpressure in reset
  assign in_ready  = !rst || !(out_valid && !out_ready);
  assign adv       = in_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld <= '0;
      mds <= '0;
    end else if (adv) begin
      vld <= {vld[2:0], in_valid};
      mds <= {mds[2:0], mode};
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    bf_lane #(
      .DW (DW),
      .Q  (Q)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .adv    (adv),
      .mode_s ({mds[2:0], mode}),
      .x      (x[l*4*DW +: 4*DW]),
      .w      (w[l*3*DW +: 3*DW]),
      .y      (y[l*4*DW +: 4*DW])
    );
  end

endmodule

// File: tb/tb_multilane_bf.sv
// Self-checking bench for multilane_bf (LANES=4) against an arithmetic reference model.
module tb_multilane_bf;
  import bf_pkg::*;

  localparam int DW    = DEF_DW;
  localparam int Q     = DEF_Q;
  localparam int LANES = 4;
  localparam int XW    = LANES * 4 * DW;
  localparam int WW    = LANES * 3 * DW;
`ifdef MULTILANE_BF_INTT_HALF_EN
  localparam bit HALF = 1'b1;
`else
  localparam bit HALF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, mode, out_valid, out_ready, out_mode;
  logic [XW-1:0] x, y;
  logic [WW-1:0] w;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multilane_bf #(.DW(DW), .Q(Q), .LANES(LANES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .x         (x),
    .w         (w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .out_mode  (out_mode)
  );

  function automatic longint md(input longint v);
    return ((v % Q) + Q) % Q;
  endfunction

  function automatic longint hv(input longint v);
    if (!HALF) return v;
    return (v % 2 == 0) ? v / 2 : (v + Q) / 2;
  endfunction

  function automatic logic [XW-1:0] model(input logic [XW-1:0] xv, input logic [WW-1:0] wv,
                                          input logic m);
    logic [XW-1:0] r;
    longint a [4];
    longint b [3];
    longint t [4];
    longint o [4];
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int k = 0; k < 4; k++) a[k] = longint'(xv[(l*4+k)*DW +: DW]);
      for (int k = 0; k < 3; k++) b[k] = longint'(wv[(l*3+k)*DW +: DW]);
      if (m == MODE_NTT) begin
        t[0] = md(a[0] + b[0] * a[2]);
        t[2] = md(a[0] - b[0] * a[2]);
        t[1] = md(a[1] + b[0] * a[3]);
        t[3] = md(a[1] - b[0] * a[3]);
        o[0] = md(t[0] + b[1] * t[1]);
        o[1] = md(t[0] - b[1] * t[1]);
        o[2] = md(t[2] + b[2] * t[3]);
        o[3] = md(t[2] - b[2] * t[3]);
      end else begin
        t[0] = hv(md(a[0] + a[1]));
        t[1] = hv(md((a[0] - a[1]) * b[1]));
        t[2] = hv(md(a[2] + a[3]));
        t[3] = hv(md((a[2] - a[3]) * b[2]));
        o[0] = hv(md(t[0] + t[2]));
        o[1] = hv(md(t[1] + t[3]));
        o[2] = hv(md((t[0] - t[2]) * b[0]));
        o[3] = hv(md((t[1] - t[3]) * b[0]));
      end
      for (int k = 0; k < 4; k++) r[(l*4+k)*DW +: DW] = DW'(o[k]);
    end
    return r;
  endfunction

  function automatic logic [4*DW-1:0] pack4(input int a, input int b, input int c, input int d);
    return {DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction

  function automatic logic [3*DW-1:0] pack3(input int a, input int b, input int c);
    return {DW'(c), DW'(b), DW'(a)};
  endfunction

  function automatic logic [XW-1:0] rnd_x();
    logic [XW-1:0] r;
    for (int i = 0; i < LANES * 4; i++) r[i*DW +: DW] = DW'($urandom_range(Q - 1, 0));
    return r;
  endfunction

  function automatic logic [WW-1:0] rnd_w();
    logic [WW-1:0] r;
    for (int i = 0; i < LANES * 3; i++) r[i*DW +: DW] = DW'($urandom_range(Q - 1, 0));
    return r;
  endfunction

  task automatic chkv(input string tag, input logic [XW-1:0] obs, input logic [XW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction: checks 4-cycle latency, result, mode and no repeat
  task automatic single(input logic [XW-1:0] xv, input logic [WW-1:0] wv, input logic m,
                        input string tag, output logic [XW-1:0] yo);
    logic [XW-1:0] e;
    e = model(xv, wv, m);
    x = xv; w = wv; mode = m; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk1({tag, "_early"}, out_valid, 1'b0);
      tick();
    end
    chk1({tag, "_valid"}, out_valid, 1'b1);
    chk1({tag, "_mode"}, out_mode, m);
    chkv({tag, "_y"}, y, e);
    for (int l = 0; l < LANES; l++)
      chkv($sformatf("%s_lane%0d", tag, l), XW'(y[l*4*DW +: 4*DW]), XW'(e[l*4*DW +: 4*DW]));
    yo = y;
    tick();
    chk1({tag, "_after"}, out_valid, 1'b0);
  endtask

  logic [XW-1:0] ey [100];
  logic          em [100];
  logic [XW-1:0] sx [3];
  logic [WW-1:0] sw [3];
  logic          sm [3];
  logic [XW-1:0] yo, xv;
  logic [WW-1:0] wv;
  logic [4*DW-1:0] intt_exp;

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; mode = MODE_NTT; x = '0; w = '0;
    #1;
    chk1("reset_in_ready_during", in_ready, 1'b1);
    tick();
    tick();
    chk1("reset_out_valid", out_valid, 1'b0);
    chkv("reset_y", y, '0);
    chk1("reset_out_mode", out_mode, 1'b0);
    chk1("reset_in_ready", in_ready, 1'b1);
    rst = 1'b1;
    tick();

    // Directed NTT / INTT reference vectors, same data in every lane
    single({LANES{pack4(1, 2, 3, 4)}}, {LANES{pack3(1, 1, 1)}}, MODE_NTT, "ntt_dir", yo);
    chkv("ntt_dir_const", XW'(yo[4*DW-1:0]), XW'(pack4(10, 3327, 3325, 0)));
    intt_exp = HALF ? pack4(1, 2, 3, 4) : pack4(4, 8, 12, 16);
    single({LANES{pack4(10, 3327, 3325, 0)}}, {LANES{pack3(1, 1, 1)}}, MODE_INTT, "intt_dir", yo);
    chkv("intt_dir_const", XW'(yo[4*DW-1:0]), XW'(intt_exp));

    // Streaming: 100 back-to-back random transactions with mixed modes
    for (int j = 0; j < 103; j++) begin
      if (j < 100) begin
        xv = rnd_x(); wv = rnd_w(); mode = 1'($urandom_range(1, 0));
        x = xv; w = wv; in_valid = 1'b1;
        ey[j] = model(xv, wv, mode);
        em[j] = mode;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      chk1("stream_in_ready", in_ready, 1'b1);
      if (j >= 3) begin
        chk1($sformatf("stream_valid_%0d", j - 3), out_valid, 1'b1);
        chkv($sformatf("stream_y_%0d", j - 3), y, ey[j-3]);
        chk1($sformatf("stream_mode_%0d", j - 3), out_mode, em[j-3]);
      end else begin
        chk1("stream_fill", out_valid, 1'b0);
      end
    end
    in_valid = 1'b0;
    tick();
    chk1("stream_drain", out_valid, 1'b0);

    // Stall: hold out_ready low for 5 cycles with three results in flight
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sx[i] = rnd_x(); sw[i] = rnd_w(); sm[i] = 1'($urandom_range(1, 0));
      x = sx[i]; w = sw[i]; mode = sm[i];
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk1("stall_pre_valid", out_valid, 1'b1);
    chkv("stall_pre_y", y, model(sx[0], sw[0], sm[0]));
    out_ready = 1'b0;
    #1;
    chk1("stall_in_ready_low", in_ready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("stall_in_ready", in_ready, 1'b0);
      chk1("stall_valid", out_valid, 1'b1);
      chkv("stall_y_stable", y, model(sx[0], sw[0], sm[0]));
      chk1("stall_mode_stable", out_mode, sm[0]);
    end
    out_ready = 1'b1;
    #1;
    chk1("stall_release_ready", in_ready, 1'b1);
    for (int i = 1; i < 3; i++) begin
      tick();
      chk1($sformatf("stall_after_valid_%0d", i), out_valid, 1'b1);
      chkv($sformatf("stall_after_y_%0d", i), y, model(sx[i], sw[i], sm[i]));
      chk1($sformatf("stall_after_mode_%0d", i), out_mode, sm[i]);
    end
    tick();
    chk1("stall_no_dup", out_valid, 1'b0);

    // Reset with transactions in flight and the output stalled
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      x = rnd_x(); w = rnd_w(); mode = MODE_INTT;
      tick();
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk1("midrst_in_ready_during", in_ready, 1'b1);
    tick();
    rst = 1'b1;
    chk1("midrst_valid", out_valid, 1'b0);
    chkv("midrst_y", y, '0);
    chk1("midrst_mode", out_mode, 1'b0);
    chk1("midrst_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk1("midrst_no_emerge", out_valid, 1'b0);
    end
    single(rnd_x(), rnd_w(), MODE_NTT, "post_rst", yo);

    // Per-lane independence with extreme values
    for (int l = 0; l < LANES; l++) begin
      xv[l*4*DW +: 4*DW] = pack4(Q - 1, l * 101 + 5, Q - 1 - l, (l * 733) % Q);
      wv[l*3*DW +: 3*DW] = pack3(Q - 1 - l, l * 37 + 2, Q - 1 - 2 * l);
    end
    single(xv, wv, MODE_NTT, "lanes_ntt", yo);
    single(xv, wv, MODE_INTT, "lanes_intt", yo);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
